// File: rtl/data_cache_if.sv
// data_cache_if: CPU-side and memory-side bus signals of the data cache.
//
// Handshake: the CPU holds cpu_read or cpu_write (with cpu_addr) asserted
// until cpu_ready is seen high in a cycle; that cycle completes the request.
// The cache raises mem_req with mem_we/mem_addr/mem_wdata and holds all four
// stable until memory returns a one-cycle mem_ack (with mem_rdata valid for
// line reads in that same cycle).
//
// The cpu_data tristate bus is not part of this interface; it is a plain
// inout port on the cache.
//
// Modports:
//   slave  - the cache side (takes CPU requests, issues memory transactions)
//   master - the CPU/memory environment side
interface data_cache_if;
    logic        cpu_read;
    logic        cpu_write;
    logic [15:0] cpu_addr;
    logic        cpu_ready;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  cpu_read,
        input  cpu_write,
        input  cpu_addr,
        output cpu_ready,
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport master (
        output cpu_read,
        output cpu_write,
        output cpu_addr,
        input  cpu_ready,
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
// Lines are four 16-bit words filled by one 64-bit memory read. Read hits
// complete in the request cycle; misses and all writes stall the CPU by
// holding cpu_ready low until memory acknowledges.
//
// Ports:
//   clk        - clock, rising edge
//   reset_n    - asynchronous active-low reset
//   bus        - data_cache_if.slave (CPU request/ready, memory req/ack)
//   cpu_data   - 16-bit tristate data: driven with the hit word during a
//                completed read, otherwise sampled as store data
//   hit_count  - read hit counter (stats build only, else 0)
//   miss_count - read miss counter (stats build only, else 0)
//   state_dbg  - current FSM state (0 IDLE, 1 FILL, 2 WRITE)
//
// Build option: define DCACHE_STATS_EN to include the hit/miss counters.
module data_cache #(
    parameter int NUM_LINES = 4,
    parameter int TAG_W     = 16 - 2 - $clog2(NUM_LINES)
) (
    input  logic              clk,
    input  logic              reset_n,
    data_cache_if.slave       bus,
    inout  wire  [15:0]       cpu_data,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count,
    output logic [1:0]        state_dbg
);
    localparam int IDX_W = $clog2(NUM_LINES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state, state_d;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [63:0]          line_mem [NUM_LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] addr_tag;
    logic [1:0]       offset;
    logic             hit;
    logic [15:0]      rd_word;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;

    assign offset   = bus.cpu_addr[1:0];
    assign idx      = bus.cpu_addr[IDX_W+1:2];
    assign addr_tag = bus.cpu_addr[15 -: TAG_W];
    assign hit      = valid[idx] && (tag_mem[idx] == addr_tag);
    assign rd_word  = line_mem[idx][{offset, 4'b0000} +: 16];

    // The latched line address of an outstanding fill names the line to
    // install, so the CPU may change or drop its request mid-miss.
    assign fill_idx = bus.mem_addr[IDX_W+1:2];
    assign fill_tag = bus.mem_addr[15 -: TAG_W];

    assign state_dbg = state;

    assign cpu_data = (bus.cpu_read && bus.cpu_ready && !bus.cpu_write) ? rd_word : 16'hzzzz;

    always_comb begin
        state_d       = state;
        bus.cpu_ready = 1'b0;
        unique case (state)
            IDLE: begin
                // A write takes priority over a simultaneous read.
                if (bus.cpu_write) begin
                    state_d = WRITE;
                end else if (bus.cpu_read) begin
                    if (hit) begin
                        bus.cpu_ready = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                // The read completes on the following IDLE cycle as a hit.
                if (bus.mem_ack) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (bus.mem_ack) begin
                    bus.cpu_ready = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            valid         <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            state <= state_d;
            unique case (state)
                IDLE: begin
                    if (bus.cpu_write) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= bus.cpu_addr;
                        bus.mem_wdata <= cpu_data;
                    end else if (bus.cpu_read && !hit) begin
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= {bus.cpu_addr[15:2], 2'b00};
                    end
                end
                FILL: begin
                    if (bus.mem_ack) begin
                        bus.mem_req     <= 1'b0;
                        valid[fill_idx] <= 1'b1;
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tags and data need no reset: a line is only looked at once its valid
    // bit is set, and reset clears every valid bit.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.cpu_write && hit) begin
            line_mem[idx][{offset, 4'b0000} +: 16] <= cpu_data;
        end
        if (state == FILL && bus.mem_ack) begin
            line_mem[fill_idx] <= bus.mem_rdata;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_q;
    logic [15:0] miss_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state == IDLE && bus.cpu_read && !bus.cpu_write) begin
            if (hit) begin
                hit_q <= hit_q + 16'd1;
            end else begin
                miss_q <= miss_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed and randomized test of data_cache against a
// line-residency model (which line address each index holds) and a flat
// reference memory. Because the cache is write-through, every read must
// return the reference memory word; the model only predicts hit/miss and
// thereby latency and memory traffic.
module tb_data_cache;
    localparam int NL = 4;

    logic        clk;
    logic        reset_n;
    wire  [15:0] cpu_data;
    logic [15:0] tb_wdata;
    logic        tb_drive;
    wire  [15:0] hit_count;
    wire  [15:0] miss_count;
    wire  [1:0]  state_dbg;

    data_cache_if bus ();

    assign cpu_data = tb_drive ? tb_wdata : 16'hzzzz;

    data_cache #(.NUM_LINES(NL)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .cpu_data   (cpu_data),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory environment ----------------
    logic [15:0] mem_arr [256];
    logic [15:0] ref_mem [256];
    int          ack_delay;
    int          txn_reads;
    int          txn_writes;

    // Acks in the ack_delay-th cycle that mem_req is seen high.
    initial begin
        int       cnt;
        bit       acked;
        logic [7:0] a;
        cnt = 0;
        acked = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (!reset_n) begin
                cnt = 0;
                acked = 0;
            end else if (bus.mem_req && !acked) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    bus.mem_ack = 1'b1;
                    a = bus.mem_addr[7:0];
                    if (bus.mem_we) begin
                        mem_arr[a] = bus.mem_wdata;
                        txn_writes++;
                    end else begin
                        a[1:0] = 2'b00;
                        bus.mem_rdata = {mem_arr[a + 8'd3], mem_arr[a + 8'd2],
                                         mem_arr[a + 8'd1], mem_arr[a]};
                        txn_reads++;
                    end
                    cnt = 0;
                    acked = 1;
                end
            end else if (!bus.mem_req) begin
                acked = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    int line_at [NL];
    int model_hits;
    int model_misses;

    function automatic int idx_of(input logic [15:0] addr);
        return int'(addr >> 2) % NL;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) line_at[i] = -1;
        model_hits = 0;
        model_misses = 0;
    endtask

    // ---------------- scoreboard ----------------
    int checks;
    int passes;
    int fails;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag);
        logic [15:0] eh;
        logic [15:0] em;
`ifdef DCACHE_STATS_EN
        eh = 16'(model_hits);
        em = 16'(model_misses);
`else
        eh = 16'd0;
        em = 16'd0;
`endif
        chk({tag, " hit_count"}, 64'(hit_count), 64'(eh));
        chk({tag, " miss_count"}, 64'(miss_count), 64'(em));
    endtask

    // ---------------- driver tasks (entered at posedge+1) ----------------
    task automatic do_read(input logic [15:0] addr);
        bit exp_hit;
        int exp_lat;
        int rd0;
        int lat;
        exp_hit = (line_at[idx_of(addr)] == int'(addr >> 2));
        exp_lat = exp_hit ? 0 : ack_delay + 1;
        rd0 = txn_reads;
        bus.cpu_read = 1'b1;
        bus.cpu_write = 1'b0;
        bus.cpu_addr = addr;
        tb_drive = 1'b0;
        lat = 0;
        #1;
        forever begin
            if (lat == 1 && !exp_hit) begin
                chk("fill mem_req", 64'(bus.mem_req), 64'd1);
                chk("fill mem_we", 64'(bus.mem_we), 64'd0);
                chk("fill mem_addr", 64'(bus.mem_addr), 64'(addr & 16'hFFFC));
            end
            if (bus.cpu_ready || lat >= 40) break;
            @(posedge clk);
            #2;
            lat++;
        end
        chk("read ready", 64'(bus.cpu_ready), 64'd1);
        chk("read latency", 64'(lat), 64'(exp_lat));
        chk("read data", 64'(cpu_data), 64'(ref_mem[addr[7:0]]));
        chk("read fills", 64'(txn_reads - rd0), exp_hit ? 64'd0 : 64'd1);
        if (!exp_hit) begin
            line_at[idx_of(addr)] = int'(addr >> 2);
            model_misses++;
        end
        model_hits++;
        @(posedge clk);
        #1;
        bus.cpu_read = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
        int wr0;
        int lat;
        wr0 = txn_writes;
        bus.cpu_read = 1'b0;
        bus.cpu_write = 1'b1;
        bus.cpu_addr = addr;
        tb_wdata = data;
        tb_drive = 1'b1;
        ref_mem[addr[7:0]] = data;
        lat = 0;
        #1;
        forever begin
            if (lat == 1) begin
                chk("write mem_req", 64'(bus.mem_req), 64'd1);
                chk("write mem_we", 64'(bus.mem_we), 64'd1);
                chk("write mem_addr", 64'(bus.mem_addr), 64'(addr));
                chk("write mem_wdata", 64'(bus.mem_wdata), 64'(data));
            end
            if (bus.cpu_ready || lat >= 40) break;
            @(posedge clk);
            #2;
            lat++;
        end
        chk("write ready", 64'(bus.cpu_ready), 64'd1);
        chk("write latency", 64'(lat), 64'(ack_delay));
        chk("write issued", 64'(txn_writes - wr0), 64'd1);
        @(posedge clk);
        #1;
        bus.cpu_write = 1'b0;
        tb_drive = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int rd0;
        int waited;
        checks = 0;
        passes = 0;
        fails = 0;
        txn_reads = 0;
        txn_writes = 0;
        ack_delay = 2;
        tb_drive = 1'b0;
        tb_wdata = '0;
        bus.cpu_read = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_addr = '0;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 16'($urandom);
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[8'h10] = 16'h0001; ref_mem[8'h10] = 16'h0001;
        mem_arr[8'h11] = 16'h0002; ref_mem[8'h11] = 16'h0002;
        mem_arr[8'h12] = 16'h0003; ref_mem[8'h12] = 16'h0003;
        mem_arr[8'h13] = 16'h0004; ref_mem[8'h13] = 16'h0004;
        model_reset();

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset mem_req", 64'(bus.mem_req), 64'd0);
        chk("reset mem_we", 64'(bus.mem_we), 64'd0);
        chk("reset mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("reset mem_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("reset cpu_ready", 64'(bus.cpu_ready), 64'd0);
        chk_stats("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Miss then same-line hit
        ack_delay = 2;
        do_read(16'h0010);
        do_read(16'h0013);

        // Write hit, then read back without memory traffic
        do_write(16'h0011, 16'hBEEF);
        do_read(16'h0011);

        // Write miss does not allocate
        do_write(16'h0040, 16'h1234);
        do_read(16'h0040);

        // Conflict misses on index 0
        do_read(16'h0000);
        do_read(16'h0010);
        do_read(16'h0000);

        // No request: cpu_ready low
        #1;
        chk("idle cpu_ready", 64'(bus.cpu_ready), 64'd0);
        chk_stats("directed");

        // Back-to-back hits on a resident line
        for (int i = 0; i < 4; i++) do_read(16'(i));

        // Fill completes although the request is dropped and the address moves
        ack_delay = 3;
        rd0 = txn_reads;
        bus.cpu_read = 1'b1;
        bus.cpu_addr = 16'h0030;
        @(posedge clk);
        #1;
        bus.cpu_read = 1'b0;
        bus.cpu_addr = 16'h0055;
        model_misses++;
        line_at[idx_of(16'h0030)] = int'(16'h0030 >> 2);
        waited = 0;
        while (txn_reads == rd0 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("dropped fill done", 64'(txn_reads - rd0), 64'd1);
        @(posedge clk);
        #1;
        do_read(16'h0031);

        // Reset in the middle of a fill
        ack_delay = 3;
        bus.cpu_read = 1'b1;
        bus.cpu_addr = 16'h0024;
        @(posedge clk);
        #2;
        chk("pre-reset mem_req", 64'(bus.mem_req), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("reset-mid-fill mem_req", 64'(bus.mem_req), 64'd0);
        chk("reset-mid-fill ready", 64'(bus.cpu_ready), 64'd0);
        bus.cpu_read = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk_stats("after reset");
        ack_delay = 2;
        do_read(16'h0024);
        do_read(16'h0010);

        // Randomized mix
        for (int n = 0; n < 80; n++) begin
            logic [15:0] a;
            ack_delay = $urandom_range(1, 4);
            a = 16'($urandom_range(0, 127));
            if ($urandom_range(0, 2) == 0) begin
                do_write(a, 16'($urandom));
            end else begin
                do_read(a);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        chk_stats("final");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "time limit reached");
    end
endmodule
